// File: rtl/quad_gen_pkg.sv
// Shared types, A/B phase tables and helpers for the quadrature step generator.
package quad_gen_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P0   = 3'd1,
        P1   = 3'd2,
        P2   = 3'd3,
        P3   = 3'd4
    } qg_state_t;

    typedef enum logic {
        DIR_CW  = 1'b0,
        DIR_CCW = 1'b1
    } qg_dir_t;

    // {A,B} resting level between detents.
    localparam logic [1:0] AB_DETENT = 2'b11;

    // Per-detent {A,B} sequences; A falls while B=1 for CW and while B=0 for CCW.
    localparam logic [1:0] CW_SEQ  [4] = '{2'b01, 2'b00, 2'b10, 2'b11};
    localparam logic [1:0] CCW_SEQ [4] = '{2'b10, 2'b00, 2'b01, 2'b11};

    // {A,B} value for phase idx of a detent in the given direction.
    function automatic logic [1:0] phase_ab(qg_dir_t dir, logic [1:0] idx);
        return (dir == DIR_CW) ? CW_SEQ[idx] : CCW_SEQ[idx];
    endfunction

endpackage

// File: rtl/quad_dwell_timer.sv
// Phase dwell timer: load arms a full phase, run counts it down and auto-reloads,
// expire_o is high in the last cycle of each PHASE_CYCLES-long phase.
module quad_dwell_timer #(
    parameter int PHASE_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic run_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(PHASE_CYCLES + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PHASE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load arms a phase, run decrements and wraps back to a full phase.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = RELOAD;
        end else if (run_i) begin
            cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expire_o = run_i && !load_i && (cnt_q == '0);

endmodule

// File: rtl/quadrature_step_generator.sv
// Quadrature step generator: emits N detents of A/B quadrature in a commanded
// direction, tracking a wrapping position count.
// Handshake: a command is taken on any rising edge where cmd_valid && cmd_ready;
// cmd_dir/cmd_count are sampled on that edge, and cmd_ready is high only in IDLE.
module quadrature_step_generator
    import quad_gen_pkg::*;
#(
    parameter int PHASE_CYCLES = 20000,
    parameter int CNT_W        = 16,
    parameter int POS_W        = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             abort,
    input  logic             pos_clr,
    output logic             enc_a,
    output logic             enc_b,
    output logic             busy,
    output logic             done,
    output logic [POS_W-1:0] position,
    output qg_state_t        dbg_state_o
);

    qg_state_t        state_q, state_d;
    logic [1:0]       ab_q, ab_d;
    qg_dir_t          dir_q, dir_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             abort_q, abort_d;
    logic             done_q, done_d;
    logic             load;
    logic             expire;
    logic             run;

    assign run = (state_q != IDLE);

    quad_dwell_timer #(
        .PHASE_CYCLES(PHASE_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load),
        .run_i    (run),
        .expire_o (expire)
    );

    // Next-state logic: phase stepping, detent accounting, abort latch and position.
    always_comb begin
        state_d = state_q;
        ab_d    = ab_q;
        dir_d   = dir_q;
        rem_d   = rem_q;
        pos_d   = pos_q;
        abort_d = abort_q;
        done_d  = 1'b0;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (cmd_valid) begin
                    dir_d = qg_dir_t'(cmd_dir);
                    if (cmd_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = P0;
                        rem_d   = cmd_count;
                        ab_d    = phase_ab(qg_dir_t'(cmd_dir), 2'd0);
                        load    = 1'b1;
                    end
                end
            end
            P0: begin
                if (abort) abort_d = 1'b1;
                if (expire) begin
                    state_d = P1;
                    ab_d    = phase_ab(dir_q, 2'd1);
                end
            end
            P1: begin
                if (abort) abort_d = 1'b1;
                if (expire) begin
                    state_d = P2;
                    ab_d    = phase_ab(dir_q, 2'd2);
                end
            end
            P2: begin
                if (abort) abort_d = 1'b1;
                if (expire) begin
                    state_d = P3;
                    ab_d    = phase_ab(dir_q, 2'd3);
                end
            end
            P3: begin
                if (abort) abort_d = 1'b1;
                if (expire) begin
                    // Detent finished: account for it, then stop or start the next one.
                    pos_d = (dir_q == DIR_CW) ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                    rem_d = rem_q - CNT_W'(1);
                    if ((rem_q == CNT_W'(1)) || abort_q || abort) begin
                        state_d = IDLE;
                        ab_d    = AB_DETENT;
                        done_d  = 1'b1;
                        abort_d = 1'b0;
                    end else begin
                        state_d = P0;
                        ab_d    = phase_ab(dir_q, 2'd0);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ab_d    = AB_DETENT;
            end
        endcase

        // Clear takes priority over a coincident detent increment.
        if (pos_clr) pos_d = '0;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ab_q    <= AB_DETENT;
            dir_q   <= DIR_CW;
            rem_q   <= '0;
            pos_q   <= '0;
            abort_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ab_q    <= ab_d;
            dir_q   <= dir_d;
            rem_q   <= rem_d;
            pos_q   <= pos_d;
            abort_q <= abort_d;
            done_q  <= done_d;
        end
    end

    assign enc_a       = ab_q[1];
    assign enc_b       = ab_q[0];
    assign cmd_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign position    = pos_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_quadrature_step_generator.sv
// Directed bench for quadrature_step_generator with PHASE_CYCLES=4.
module tb_quadrature_step_generator;
    import quad_gen_pkg::*;

    localparam int PC    = 4;
    localparam int CNT_W = 16;
    localparam int POS_W = 24;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_count;
    logic             abort;
    logic             pos_clr;
    logic             enc_a;
    logic             enc_b;
    logic             busy;
    logic             done;
    logic [POS_W-1:0] position;
    qg_state_t        dbg_state;

    int checks;
    int errors;

    logic [1:0] exp_cw  [4];
    logic [1:0] exp_ccw [4];

    typedef struct {
        logic              dir;
        int                count;
        logic              clr_first;
        logic [POS_W-1:0]  exp_pos;
    } vec_t;

    vec_t vecs [4];

    quadrature_step_generator #(
        .PHASE_CYCLES(PC),
        .CNT_W       (CNT_W),
        .POS_W       (POS_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_dir     (cmd_dir),
        .cmd_count   (cmd_count),
        .abort       (abort),
        .pos_clr     (pos_clr),
        .enc_a       (enc_a),
        .enc_b       (enc_b),
        .busy        (busy),
        .done        (done),
        .position    (position),
        .dbg_state_o (dbg_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Present one command and return just after the accepting edge.
    task automatic send_cmd(input logic dir, input int count);
        @(negedge clk);
        chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_count = CNT_W'(count);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic pulse_pos_clr();
        @(negedge clk);
        pos_clr = 1'b1;
        @(posedge clk);
        #1 pos_clr = 1'b0;
        @(negedge clk);
        chk("pos_clr", 32'(position), 32'd0);
    endtask

    // Follow n detents cycle by cycle, then expect the single done cycle.
    task automatic check_detents(input logic dir, input int n);
        logic [1:0] prev;
        logic [1:0] cur;
        logic [1:0] exp;
        prev = 2'b11;
        for (int d = 0; d < n; d++) begin
            for (int p = 0; p < 4; p++) begin
                for (int c = 0; c < PC; c++) begin
                    @(negedge clk);
                    cur = {enc_a, enc_b};
                    exp = dir ? exp_ccw[p] : exp_cw[p];
                    chk("ab_phase", 32'(cur), 32'(exp));
                    chk("gray_step", 32'($countones(prev ^ cur) <= 1), 32'd1);
                    chk("busy_during", 32'(busy), 32'd1);
                    chk("no_early_done", 32'(done), 32'd0);
                    chk("ready_low_busy", 32'(cmd_ready), 32'd0);
                    prev = cur;
                end
            end
        end
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_end", 32'(busy), 32'd0);
        chk("ready_end", 32'(cmd_ready), 32'd1);
        chk("ab_end", 32'({enc_a, enc_b}), 32'd3);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int done_cyc;
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_count = '0;
        abort     = 1'b0;
        pos_clr   = 1'b0;

        exp_cw[0]  = 2'b01; exp_cw[1]  = 2'b00; exp_cw[2]  = 2'b10; exp_cw[3]  = 2'b11;
        exp_ccw[0] = 2'b10; exp_ccw[1] = 2'b00; exp_ccw[2] = 2'b01; exp_ccw[3] = 2'b11;

        vecs[0] = '{dir: 1'b0, count: 1, clr_first: 1'b1, exp_pos: 24'h000001};
        vecs[1] = '{dir: 1'b1, count: 3, clr_first: 1'b1, exp_pos: 24'hFFFFFD};
        vecs[2] = '{dir: 1'b0, count: 2, clr_first: 1'b0, exp_pos: 24'hFFFFFF};
        vecs[3] = '{dir: 1'b0, count: 1, clr_first: 1'b0, exp_pos: 24'h000000};

        // Reset state.
        do_reset(2);
        @(negedge clk);
        chk("rst_a", 32'(enc_a), 32'd1);
        chk("rst_b", 32'(enc_b), 32'd1);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pos", 32'(position), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));

        // Table-driven detent commands.
        for (int i = 0; i < 4; i++) begin
            if (vecs[i].clr_first) pulse_pos_clr();
            send_cmd(vecs[i].dir, vecs[i].count);
            check_detents(vecs[i].dir, vecs[i].count);
            chk("vec_pos", 32'(position), 32'(vecs[i].exp_pos));
        end

        // Command held off while busy; abort in P1 of detent 2 ends after that detent.
        pulse_pos_clr();
        send_cmd(1'b0, 5);
        done_cyc = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == 2) begin
                cmd_valid = 1'b1;
                cmd_count = CNT_W'(9);
                cmd_dir   = 1'b0;
            end
            if (c >= 2 && c <= 10) chk("ready_held_off", 32'(cmd_ready), 32'd0);
            if (c == 10) cmd_valid = 1'b0;
            if (c == 22) abort = 1'b1;
            if (c == 23) abort = 1'b0;
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        chk("abort_done_cycle", 32'(done_cyc), 32'd33);
        chk("abort_pos", 32'(position), 32'd2);
        chk("abort_ab", 32'({enc_a, enc_b}), 32'd3);
        chk("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("abort_no_reaccept", 32'(busy), 32'd0);

        // Abort in IDLE is ignored: next command runs its full length.
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        send_cmd(1'b0, 1);
        check_detents(1'b0, 1);
        chk("idle_abort_pos", 32'(position), 32'd3);

        // Zero-count command.
        send_cmd(1'b1, 0);
        @(negedge clk);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_ab", 32'({enc_a, enc_b}), 32'd3);
        @(negedge clk);
        chk("zero_done_once", 32'(done), 32'd0);
        chk("zero_busy2", 32'(busy), 32'd0);
        chk("zero_pos", 32'(position), 32'd3);

        // Clear coinciding with a detent completion wins.
        send_cmd(1'b0, 1);
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            if (c == 16) pos_clr = 1'b1;
            if (c == 17) begin
                pos_clr = 1'b0;
                chk("clr_at_end_done", 32'(done), 32'd1);
                chk("clr_at_end_pos", 32'(position), 32'd0);
            end
        end

        // Reset in the middle of a detent.
        send_cmd(1'b0, 1);
        check_detents(1'b0, 1);
        chk("pre_rst_pos", 32'(position), 32'd1);
        send_cmd(1'b1, 2);
        for (int c = 1; c <= 10; c++) @(negedge clk);
        chk("mid_ab_p2", 32'({enc_a, enc_b}), 32'b01);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_ab", 32'({enc_a, enc_b}), 32'd3);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_pos", 32'(position), 32'd0);
        chk("midrst_ready", 32'(cmd_ready), 32'd1);
        chk("midrst_done", 32'(done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
